// File: rtl/mult_div_unit_pkg.sv
// ============================================================================
// Module   : mult_div_unit_pkg
// Brief    : MDU operation encodings, FSM state encodings and the result helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mult_div_unit_pkg;

    localparam logic [3:0] c_mdu_none  = 4'd0;
    localparam logic [3:0] c_mdu_mult  = 4'd1;
    localparam logic [3:0] c_mdu_multu = 4'd2;
    localparam logic [3:0] c_mdu_div   = 4'd3;
    localparam logic [3:0] c_mdu_divu  = 4'd4;
    localparam logic [3:0] c_mdu_mfhi  = 4'd5;
    localparam logic [3:0] c_mdu_mflo  = 4'd6;
    localparam logic [3:0] c_mdu_mthi  = 4'd7;
    localparam logic [3:0] c_mdu_mtlo  = 4'd8;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // Returns {hi, lo}. A zero divisor is swapped for 1 only to keep the
    // arithmetic defined; the caller discards that result.
    function automatic logic [63:0] mdu_calc(input logic [3:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] res;
        logic [31:0] d;
        res = '0;
        d   = (b == 32'd0) ? 32'd1 : b;
        case (op)
            c_mdu_mult:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            c_mdu_multu: res = {32'd0, a} * {32'd0, b};
            c_mdu_div: begin
                if (a == 32'h8000_0000 && d == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else
                    res = {32'($signed(a) % $signed(d)), 32'($signed(a) / $signed(d))};
            end
            c_mdu_divu:  res = {a % d, a / d};
            default:     res = '0;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : E-stage multiply/divide unit with fixed latency, owns HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_out
);

    localparam int CNT_W = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_temp_hi;
    logic [31:0]      r_temp_lo;
    logic             r_hold;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_is_mul;
    logic             w_is_div;
    logic [63:0]      w_result;

    assign w_is_mul = (mdu_op == c_mdu_mult) || (mdu_op == c_mdu_multu);
    assign w_is_div = (mdu_op == c_mdu_div)  || (mdu_op == c_mdu_divu);
    assign w_result = mdu_calc(mdu_op, A, B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_temp_hi <= '0;
            r_temp_lo <= '0;
            r_hold    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start && (w_is_mul || w_is_div)) begin
                        r_temp_hi <= w_result[63:32];
                        r_temp_lo <= w_result[31:0];
                        r_hold    <= w_is_div && (B == 32'd0);
                        r_cnt     <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_state   <= c_st_run;
                    end else if (!start && mdu_op == c_mdu_mthi) begin
                        r_hi <= A;
                    end else if (!start && mdu_op == c_mdu_mtlo) begin
                        r_lo <= A;
                    end
                end
                c_st_run: begin
                    // Result is committed on the final countdown edge so it is
                    // visible in the same cycle busy drops.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= c_st_idle;
                        if (!r_hold) begin
                            r_hi <= r_temp_hi;
                            r_lo <= r_temp_lo;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy    = (r_state == c_st_run);
    assign HI      = r_hi;
    assign LO      = r_lo;
    assign mdu_out = (mdu_op == c_mdu_mfhi) ? r_hi :
                     (mdu_op == c_mdu_mflo) ? r_lo : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    localparam logic [3:0] c_op_none  = 4'd0;
    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mfhi  = 4'd5;
    localparam logic [3:0] c_op_mflo  = 4'd6;
    localparam logic [3:0] c_op_mthi  = 4'd7;
    localparam logic [3:0] c_op_mtlo  = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  mdu_op;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdu_op  (mdu_op),
        .start   (start),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .mdu_out (mdu_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic in 64-bit integers, MIPS HI/LO semantics.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            c_op_mult:  begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
            c_op_multu: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
            c_op_div: if (b != 32'd0) begin
                q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0];
            end
            c_op_divu: if (b != 32'd0) begin
                m_lo = a / b; m_hi = a % b;
            end
            default: ;
        endcase
    endtask

    // inj 1: mtlo during busy cycle 1; inj 2: a div start during busy cycle 2
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int inj);
        int exp_n;
        int n;
        exp_n  = (op == c_op_mult || op == c_op_multu) ? 5 : 10;
        mdu_op = op; start = 1'b1; A = a; B = b;
        chk("busy_in_start_cycle", {31'd0, busy}, 32'd0);
        step;
        mdu_op = c_op_none; start = 1'b0; A = $urandom; B = $urandom;
        model(op, a, b);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (inj == 1 && n == 1) begin mdu_op = c_op_mtlo; A = 32'hDEAD_BEEF; end
            if (inj == 2 && n == 2) begin mdu_op = c_op_div; start = 1'b1; A = 32'd100; B = 32'd7; end
            step;
            mdu_op = c_op_none; start = 1'b0;
        end
        chk("busy_cycles", 32'(n), 32'(exp_n));
        chk("hi_commit", HI, m_hi);
        chk("lo_commit", LO, m_lo);
    endtask

    task automatic read_back;
        mdu_op = c_op_mfhi; #1;
        chk("mfhi", mdu_out, m_hi);
        mdu_op = c_op_mflo; #1;
        chk("mflo", mdu_out, m_lo);
        mdu_op = c_op_none;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] v);
        mdu_op = op; start = 1'b0; A = v;
        step;
        mdu_op = c_op_none;
        if (op == c_op_mthi) m_hi = v; else m_lo = v;
        chk("move_hi", HI, m_hi);
        chk("move_lo", LO, m_lo);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        rst_n = 1'b0; mdu_op = c_op_none; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        rst_n = 1'b1;
        step;

        run_op(c_op_mult,  32'hFFFF_FFFE, 32'd3, 0); read_back;
        run_op(c_op_multu, 32'hFFFF_FFFF, 32'd2, 0); read_back;
        run_op(c_op_div,   32'hFFFF_FFF9, 32'd2, 0); read_back;
        run_op(c_op_divu,  32'd7,         32'd0, 0); read_back;
        run_op(c_op_div,   32'h8000_0000, 32'hFFFF_FFFF, 0); read_back;
        move_to(c_op_mthi, 32'h1234_5678);            read_back;

        // non-MDU op with start=1 must not write HI
        mdu_op = c_op_mthi; start = 1'b1; A = 32'h5555_5555;
        step;
        mdu_op = c_op_none; start = 1'b0;
        chk("start_other_op_busy", {31'd0, busy}, 32'd0);
        chk("start_other_op_hi", HI, m_hi);

        run_op(c_op_mult, 32'd1000, 32'hFFFF_FF00, 1); read_back;
        run_op(c_op_mult, 32'h0001_0001, 32'h0000_FFFF, 2);
        run_op(c_op_div,  32'hFFFF_FF00, 32'd9, 0); read_back;

        // reset in the middle of a divide
        mdu_op = c_op_divu; start = 1'b1; A = 32'd1000; B = 32'd3;
        step;
        mdu_op = c_op_none; start = 1'b0;
        repeat (3) step;
        chk("busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; #1;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
        chk("midrun_reset_hi", HI, 32'd0);
        chk("midrun_reset_lo", LO, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) step;
        chk("no_late_commit_busy", {31'd0, busy}, 32'd0);
        chk("no_late_commit_hi", HI, 32'd0);
        chk("no_late_commit_lo", LO, 32'd0);

        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: op = c_op_mult;
                1: op = c_op_multu;
                2: op = c_op_div;
                3: op = c_op_divu;
                4: op = c_op_mthi;
                default: op = c_op_mtlo;
            endcase
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
            if (op == c_op_div && $urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (op == c_op_mthi || op == c_op_mtlo) move_to(op, a);
            else run_op(op, a, b, 0);
            read_back;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
